// File: rtl/the_wrapper_file_pkg.sv
// Shared definitions for the AHB-Lite AES wrapper: bus encodings, address map,
// status layout, state enums and the AES round helper functions.
package the_wrapper_file_pkg;

  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  // Word addresses (HADDR[7:2]).
  localparam logic [5:0] AddrStatus  = 6'h00;
  localparam logic [5:0] AddrModeEnc = 6'h01;
  localparam logic [5:0] AddrModeDec = 6'h02;
  localparam logic [3:0] AddrKeyPage = 4'h1;   // word address [5:2], 0x10..0x1C
  localparam logic [1:0] AddrInPage  = 2'b01;  // word address [5:4], 0x40..0x7C
  localparam logic [1:0] AddrOutPage = 2'b10;  // word address [5:4], 0x80..0xBC

  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusDoneLsb = 4;
  localparam int unsigned StatusModeBit = 8;

  typedef enum logic [1:0] {SeqIdle, SeqStart, SeqWait} seq_state_e;
  typedef enum logic [1:0] {CoreIdle, CoreExpand, CoreRound} core_state_e;

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] k;
    k = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) k = 2'(i);
    return k;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse in GF(2^8) as x^254 (maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(gmul(x15, x15), gmul(x15, x15));
    x240 = gmul(gmul(x240, x240), gmul(x240, x240));
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
    logic [7:0] b;
    if (!inv) begin
      b = ginv(x);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
    b = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
    return ginv(b);
  endfunction

  // Byte 0 of the state is bits [127:120]; byte index = row + 4*column.
  function automatic logic [127:0] sub_bytes(input logic [127:0] st, input logic inv);
    logic [127:0] o;
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = sbox(st[127-8*j -: 8], inv);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] st, input logic inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? r + 4 * ((c - r + 4) % 4) : r + 4 * ((c + r) % 4);
        o[127-8*(r+4*c) -: 8] = st[127-8*src -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] st, input logic inv);
    logic [127:0] o;
    logic [7:0] m [4];
    logic [7:0] acc;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(st[127-8*(j+4*c) -: 8], m[(j-r+4)%4]);
        o[127-8*(r+4*c) -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    unique case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] w, input logic [3:0] rnd);
    return {sbox(w[23:16], 1'b0), sbox(w[15:8], 1'b0), sbox(w[7:0], 1'b0),
            sbox(w[31:24], 1'b0)} ^ {rcon(rnd), 24'h0};
  endfunction

  // Round key rnd from round key rnd-1.
  function automatic logic [127:0] key_fwd(input logic [127:0] w, input logic [3:0] rnd);
    logic [31:0] n0, n1, n2, n3;
    n0 = w[127:96] ^ subrot(w[31:0], rnd);
    n1 = w[95:64] ^ n0;
    n2 = w[63:32] ^ n1;
    n3 = w[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Round key rnd-1 from round key rnd.
  function automatic logic [127:0] key_bwd(input logic [127:0] w, input logic [3:0] rnd);
    logic [31:0] p0, p1, p2, p3;
    p3 = w[31:0] ^ w[63:32];
    p2 = w[63:32] ^ w[95:64];
    p1 = w[95:64] ^ w[127:96];
    p0 = w[127:96] ^ subrot(p3, rnd);
    return {p0, p1, p2, p3};
  endfunction

endpackage

// File: rtl/the_wrapper_file_aes_core.sv
// Iterative AES-128 core: one round per cycle. Decrypt first walks the key
// schedule forward to the last round key, then runs it backwards.
module aes_core
  import the_wrapper_file_pkg::*;
(
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         start,
  input  logic         decrypt,
  input  logic [127:0] key,
  input  logic [127:0] din,
  output logic [127:0] dout,
  output logic         done
);

  core_state_e  state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] st_q, st_d, rk_q, rk_d;
  logic         dec_q, dec_d, done_q, done_d;

  // Datapath and round counter registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= CoreIdle;
      round_q <= 4'd0;
      st_q    <= '0;
      rk_q    <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  // Round sequencing; round_q counts up for encrypt/expansion, down for decrypt.
  always_comb begin
    logic [127:0] nk, t;
    state_d = state_q;
    round_d = round_q;
    st_d    = st_q;
    rk_d    = rk_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    nk      = '0;
    t       = '0;
    unique case (state_q)
      CoreIdle: begin
        if (start) begin
          dec_d   = decrypt;
          rk_d    = key;
          round_d = 4'd1;
          st_d    = decrypt ? din : din ^ key;
          state_d = decrypt ? CoreExpand : CoreRound;
        end
      end
      CoreExpand: begin
        nk      = key_fwd(rk_q, round_q);
        rk_d    = nk;
        round_d = round_q + 4'd1;
        if (round_q == 4'd10) begin
          st_d    = st_q ^ nk;
          round_d = 4'd9;
          state_d = CoreRound;
        end
      end
      CoreRound: begin
        if (!dec_q) begin
          nk = key_fwd(rk_q, round_q);
          t  = shift_rows(sub_bytes(st_q, 1'b0), 1'b0);
          if (round_q != 4'd10) t = mix_columns(t, 1'b0);
          st_d    = t ^ nk;
          rk_d    = nk;
          round_d = round_q + 4'd1;
          if (round_q == 4'd10) begin
            done_d  = 1'b1;
            state_d = CoreIdle;
          end
        end else begin
          nk = key_bwd(rk_q, round_q + 4'd1);
          t  = sub_bytes(shift_rows(st_q, 1'b1), 1'b1) ^ nk;
          if (round_q != 4'd0) t = mix_columns(t, 1'b1);
          st_d = t;
          rk_d = nk;
          if (round_q == 4'd0) begin
            done_d  = 1'b1;
            state_d = CoreIdle;
          end else begin
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = CoreIdle;
    endcase
  end

  assign dout = st_q;
  assign done = done_q;

endmodule

// File: rtl/the_wrapper_file.sv
// AHB-Lite slave front end for the AES core: bus decode, key/mode registers,
// four-block input and output buffers and the block sequencer.
module the_wrapper_file
  import the_wrapper_file_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELx,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP
);

  logic [31:0] key_q [4];
  logic [31:0] in_buf_q [16];
  logic [31:0] out_buf_q [16];
  logic        mode_q;
  logic [3:0]  pending_q, pending_d, done_q, done_d;
  seq_state_e  state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic        wr_q;
  logic [5:0]  waddr_q, raddr;
  logic [31:0] rdata_q, rd_word, status;
  logic        valid, busy, in_wr, fwd_ok;
  logic        core_start, core_done;
  logic [127:0] core_dout;

  logic unused_bus;
  assign unused_bus = ^{HBURST, HPROT, HSIZE, HADDR[31:8], HADDR[1:0]};

  assign valid  = HSELx && (HTRANS == HtransNonseq || HTRANS == HtransSeq);
  assign raddr  = HADDR[7:2];
  assign in_wr  = wr_q && (waddr_q[5:4] == AddrInPage);
  assign busy   = (state_q != SeqIdle) || (|pending_q);
  assign HREADY = 1'b1;
  assign HRESP  = 2'b00;
  assign HRDATA = rdata_q;

  // Status word assembly.
  always_comb begin
    status = '0;
    status[StatusBusyBit] = busy;
    status[StatusDoneLsb +: 4] = done_q;
    status[StatusModeBit] = mode_q;
  end

  // Read decode; a write still in its data phase to the same RW word is forwarded.
  always_comb begin
    rd_word = '0;
    if (raddr == AddrStatus)              rd_word = status;
    else if (raddr[5:2] == AddrKeyPage)   rd_word = key_q[raddr[1:0]];
    else if (raddr[5:4] == AddrInPage)    rd_word = in_buf_q[raddr[3:0]];
    else if (raddr[5:4] == AddrOutPage)   rd_word = out_buf_q[raddr[3:0]];
    fwd_ok = (raddr[5:2] == AddrKeyPage) || (raddr[5:4] == AddrInPage);
    if (wr_q && waddr_q == raddr && fwd_ok) rd_word = HWDATA;
  end

  // Address-phase capture and registered read data.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_q    <= 1'b0;
      waddr_q <= '0;
      rdata_q <= '0;
    end else begin
      wr_q    <= valid && HWRITE;
      waddr_q <= raddr;
      rdata_q <= (valid && !HWRITE) ? rd_word : '0;
    end
  end

  // Data-phase write commit to mode, key and input buffer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mode_q <= 1'b0;
      for (int i = 0; i < 4; i++) key_q[i] <= '0;
      for (int i = 0; i < 16; i++) in_buf_q[i] <= '0;
    end else if (wr_q) begin
      if (waddr_q == AddrModeEnc) mode_q <= 1'b0;
      if (waddr_q == AddrModeDec) mode_q <= 1'b1;
      if (waddr_q[5:2] == AddrKeyPage) key_q[waddr_q[1:0]] <= HWDATA;
      if (in_wr) in_buf_q[waddr_q[3:0]] <= HWDATA;
    end
  end

  // Sequencer, pending/done flags and output buffer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= SeqIdle;
      sel_q     <= 2'd0;
      pending_q <= '0;
      done_q    <= '0;
      for (int i = 0; i < 16; i++) out_buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      if (state_q == SeqWait && core_done) begin
        for (int j = 0; j < 4; j++) out_buf_q[{sel_q, 2'(j)}] <= core_dout[127-32*j -: 32];
      end
    end
  end

  // Next-state: a new last-word write re-arms a block even as it is started.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    pending_d  = pending_q;
    done_d     = done_q;
    core_start = 1'b0;
    unique case (state_q)
      SeqIdle: begin
        if (|pending_q) begin
          sel_d   = lowest_set(pending_q);
          state_d = SeqStart;
        end
      end
      SeqStart: begin
        core_start        = 1'b1;
        pending_d[sel_q]  = 1'b0;
        state_d           = SeqWait;
      end
      SeqWait: begin
        if (core_done) begin
          done_d[sel_q] = 1'b1;
          state_d       = SeqIdle;
        end
      end
      default: state_d = SeqIdle;
    endcase
    if (in_wr) begin
      done_d[waddr_q[3:2]] = 1'b0;
      if (waddr_q[1:0] == 2'b11) pending_d[waddr_q[3:2]] = 1'b1;
    end
  end

  aes_core u_aes_core (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .start   (core_start),
    .decrypt (mode_q),
    .key     ({key_q[0], key_q[1], key_q[2], key_q[3]}),
    .din     ({in_buf_q[{sel_q, 2'd0}], in_buf_q[{sel_q, 2'd1}],
               in_buf_q[{sel_q, 2'd2}], in_buf_q[{sel_q, 2'd3}]}),
    .dout    (core_dout),
    .done    (core_done)
  );

endmodule

// File: tb/tb_the_wrapper_file.sv
// Scoreboard bench for the AHB-Lite AES wrapper using FIPS-197 AES-128 vectors.
module tb_the_wrapper_file;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELx;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HBURST, HSIZE;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS, HRESP;
  logic        HWRITE, HREADY;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] wdat [16];
  logic [31:0] rdat [16];
  logic [31:0] pt [4];
  logic [31:0] ct [4];

  the_wrapper_file dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .HSELx   (HSELx),
    .HADDR   (HADDR),
    .HWDATA  (HWDATA),
    .HBURST  (HBURST),
    .HPROT   (HPROT),
    .HSIZE   (HSIZE),
    .HTRANS  (HTRANS),
    .HWRITE  (HWRITE),
    .HRDATA  (HRDATA),
    .HREADY  (HREADY),
    .HRESP   (HRESP)
  );

  initial forever #5 HCLK = ~HCLK;

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input bit c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.chk  = c;
    sb_q.push_back(e);
  endtask

  task automatic bus_idle();
    HSELx  = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  // Pipelined INCR (or SINGLE when n==1) burst; reads queue rdat[] as expectations.
  task automatic bus_xfer(input bit write, input logic [31:0] base, input int n, input bit chk);
    for (int i = 0; i <= n; i++) begin
      @(posedge HCLK); #1;
      if (write && i > 0) HWDATA = wdat[i-1];
      if (i < n) begin
        HSELx  = 1'b1;
        HTRANS = (i == 0) ? 2'b10 : 2'b11;
        HWRITE = write;
        HBURST = (n > 1) ? 3'b001 : 3'b000;
        HADDR  = base + 32'(4 * i);
        if (!write) push_exp(HADDR, rdat[i], chk);
      end else begin
        bus_idle();
      end
    end
  endtask

  // Write one word and read the same address in the very next address phase.
  task automatic wr_rd(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
    @(posedge HCLK); #1;
    HSELx = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HBURST = 3'b000; HADDR = a;
    @(posedge HCLK); #1;
    HWDATA = d; HWRITE = 1'b0;
    push_exp(a, exp, 1'b1);
    @(posedge HCLK); #1;
    bus_idle();
  endtask

  task automatic read_status(output logic [31:0] s);
    @(posedge HCLK); #1;
    HSELx = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HBURST = 3'b000; HADDR = 32'h0;
    push_exp(32'h0, 32'h0, 1'b0);
    @(posedge HCLK); #1;
    bus_idle();
    s = HRDATA;
  endtask

  task automatic poll_bit(input int bitn, input string name);
    logic [31:0] s;
    logic        seen;
    seen = 1'b0;
    for (int p = 0; p < 200 && !seen; p++) begin
      read_status(s);
      seen = s[bitn];
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Monitor: a read address phase at a posedge presents HRDATA until the next one.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge HCLK);
      if (HRESETn && HSELx && HTRANS[1] && !HWRITE) begin
        @(negedge HCLK);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual=%08h expected=none", HRDATA);
        end else begin
          e = sb_q.pop_front();
          if (e.chk) check($sformatf("rd_%02h", e.addr[7:0]), HRDATA, e.data);
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] s;
    int t [4];
    pt = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    ct = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
    HRESETn = 1'b0;
    HADDR = '0; HWDATA = '0; HBURST = '0; HPROT = '0; HSIZE = 3'b010;
    bus_idle();
    #13;
    check("rst_hready", 32'(HREADY), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    rdat[0] = 32'h0;
    bus_xfer(1'b0, 32'h00, 1, 1'b1);

    // Key load and readback.
    wdat[0:3] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    bus_xfer(1'b1, 32'h10, 4, 1'b0);
    rdat[0:3] = wdat[0:3];
    bus_xfer(1'b0, 32'h10, 4, 1'b1);
    rdat[0] = 32'h0;
    bus_xfer(1'b0, 32'h00, 1, 1'b1);

    // Single-block encrypt.
    bus_xfer(1'b1, 32'h04, 1, 1'b0);
    for (int i = 0; i < 4; i++) wdat[i] = pt[i];
    bus_xfer(1'b1, 32'h40, 4, 1'b0);
    poll_bit(4, "enc_done0");
    for (int i = 0; i < 4; i++) rdat[i] = ct[i];
    bus_xfer(1'b0, 32'h80, 4, 1'b1);
    rdat[0] = 32'h0000_0010;
    bus_xfer(1'b0, 32'h00, 1, 1'b1);

    // Decrypt into block 1.
    bus_xfer(1'b1, 32'h08, 1, 1'b0);
    for (int i = 0; i < 4; i++) wdat[i] = ct[i];
    bus_xfer(1'b1, 32'h50, 4, 1'b0);
    poll_bit(5, "dec_done1");
    for (int i = 0; i < 4; i++) rdat[i] = pt[i];
    bus_xfer(1'b0, 32'h90, 4, 1'b1);
    rdat[0] = 32'h0000_0130;
    bus_xfer(1'b0, 32'h00, 1, 1'b1);

    // Four blocks encrypted from one 16-beat burst.
    bus_xfer(1'b1, 32'h04, 1, 1'b0);
    for (int i = 0; i < 16; i++) wdat[i] = pt[i % 4];
    bus_xfer(1'b1, 32'h40, 16, 1'b0);
    for (int k = 0; k < 4; k++) t[k] = -1;
    for (int p = 0; p < 400; p++) begin
      read_status(s);
      for (int k = 0; k < 4; k++) if (s[4+k] && t[k] < 0) t[k] = p;
      if (s == 32'h0000_00f0) break;
    end
    check("done0_seen", 32'(t[0] >= 0), 32'd1);
    for (int k = 0; k < 3; k++)
      check($sformatf("done_order_%0d", k), 32'(t[k] >= 0 && t[k] < t[k+1]), 32'd1);
    rdat[0] = 32'h0000_00f0;
    bus_xfer(1'b0, 32'h00, 1, 1'b1);
    for (int i = 0; i < 16; i++) rdat[i] = ct[i % 4];
    bus_xfer(1'b0, 32'h80, 16, 1'b1);

    // Reset while block 0 is inside the core.
    for (int i = 0; i < 4; i++) wdat[i] = pt[i];
    bus_xfer(1'b1, 32'h40, 4, 1'b0);
    repeat (5) @(posedge HCLK);
    #2 HRESETn = 1'b0;
    #15;
    @(negedge HCLK);
    HRESETn = 1'b1;
    rdat[0] = 32'h0;
    bus_xfer(1'b0, 32'h00, 1, 1'b1);
    for (int i = 0; i < 16; i++) rdat[i] = 32'h0;
    bus_xfer(1'b0, 32'h80, 16, 1'b1);
    repeat (30) @(posedge HCLK);
    bus_xfer(1'b0, 32'h00, 1, 1'b1);
    bus_xfer(1'b0, 32'h10, 1, 1'b1);
    bus_xfer(1'b0, 32'h40, 4, 1'b1);
    wr_rd(32'h80, 32'h1234_5678, 32'h0);
    wr_rd(32'h44, 32'hdead_beef, 32'hdead_beef);
    wr_rd(32'h18, 32'hcafe_f00d, 32'hcafe_f00d);
    rdat[0] = 32'h0;
    bus_xfer(1'b0, 32'h00, 1, 1'b1);

    repeat (5) @(posedge HCLK);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/the_wrapper_file.md
# the_wrapper_file

AHB-Lite slave wrapper around a 128-bit AES block cipher core. A bus master uses it to load a 128-bit key, select encrypt or decrypt mode, and write up to four 128-bit data blocks. It then polls status and reads the processed blocks back. It is the top-level bus-facing block of the crypto accelerator.

## Interface
- Parameters: none; the address map and block count (4) are fixed.
- HCLK  in  1  single system clock; all state on rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSELx  in  1  slave select.
- HADDR  in  32  byte address; bits [7:2] decoded.
- HWDATA  in  32  write data, valid in data phase.
- HBURST  in  3  accepted, ignored (SINGLE/INCR both work).
- HPROT  in  4  ignored.
- HSIZE  in  3  ignored; every transfer treated as 32-bit word.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1=write.
- HRDATA  out  32  read data, valid in data phase.
- HREADY  out  1  constant 1 (no wait states).
- HRESP  out  2  constant 00 (OKAY).

## Operation
- A transfer is valid when HSELx=1 and HTRANS is NONSEQ or SEQ. Address and write are latched at the address phase; a write commits HWDATA at the end of the following (data) cycle.
- Address map:
  - 0x00 status (RO): bit0 busy, bits[7:4] done[3:0], bit8 mode (1=decrypt).
  - 0x04 write (any data): mode=encrypt.
  - 0x08 write (any data): mode=decrypt.
  - 0x10..0x1C key (RW): 0x10=key[127:96] … 0x1C=key[31:0].
  - 0x40..0x7C input buffer (RW), block k at 0x40+16k, first word = bits[127:96].
  - 0x80..0xBC output buffer (RO), same layout.
  - Unmapped reads return 0; unmapped writes and writes to RO regions are ignored.
- Writing any word of block k clears done[k]. Writing its last word (0x4C/0x5C/0x6C/0x7C) sets pending[k]. Re-setting an already pending block leaves it pending once.
- Sequencer states:
  - IDLE: if any pending, select the lowest k and go to START.
  - START: 1-cycle start pulse to the core with the block, key and mode; clear pending[k]; go to WAIT.
  - WAIT: on core done, write dout to output block k, set done[k], go to IDLE.
- busy = state≠IDLE or any pending.
- Key and mode changes affect only later STARTs; the core latches its inputs at start.
- Reset values: all registers, buffers, pending and done are 0; mode=encrypt; state IDLE; HRDATA=0.
- Asynchronous reset mid-operation aborts the core and clears everything above.

## Timing
- Read: HRDATA is registered at the address-phase edge, so it is valid through the data phase. Back-to-back INCR reads give one word per cycle.
- Read/update collision: a read whose address-phase edge coincides with a buffer or status update returns the pre-update value.
- Write followed immediately by a read of the same address returns the new value.
- pending[k] is set at the edge ending the last word's data phase. START follows 1 cycle later, the start pulse 1 cycle after that. Output is valid and done[k] set on the edge the core signals done. Core latency L is arbitrary ≥1.

## Structure
- Shared package: HTRANS encoding, address constants, status bit positions, sequencer state enum.
- One sub-module, aes_core (specified separately): ports HCLK, HRESETn, start, decrypt, key[127:0], din[127:0], dout[127:0], done (1-cycle pulse). It contains the key schedule.
- The wrapper holds bus decode, register file, buffers and sequencer.

## Test plan
- Reset: HREADY=1, HRESP=00, HRDATA=0; read 0x00 → 0.
- Key INCR burst 0x10..0x1C with 00010203, 04050607, 08090a0b, 0c0d0e0f → reads return the same words; 0x00 stays 0.
- Encrypt:
  - Stimulus: write 0x04; write 00112233, 44556677, 8899aabb, ccddeeff to 0x40..0x4C; poll until status bit4=1.
  - Response: 0x80..0x8C read 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
- Decrypt:
  - Stimulus: write 0x08; write that ciphertext to 0x50..0x5C.
  - Response: 0x90..0x9C read 00112233, 44556677, 8899aabb, ccddeeff; status bit8=1.
- Four blocks, encrypt: 16-beat INCR write 0x40..0x7C, each block being the plaintext above → done bits set in order 0,1,2,3; final status 0xF0; all four outputs equal the expected ciphertext. A 16-beat INCR read 0x80..0xBC returns them one word per cycle.
- HRESETn low during WAIT → status 0, output buffer 0, no done later. A write to 0x80 is ignored.
